uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo_fifo.sv | 59 +++++
 rtl/uart_tx_fifo.sv | 129 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int   DEFAULT_CLK_DIV = 868;
  localparam int   DATA_BITS       = 8;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte write handshake plus serial line and status of the UART transmitter
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_valid_i;
  logic [7:0]       wr_data_i;
  logic             wr_ready_o;
  logic             tx_o;
  logic             busy_o;
  logic [CNT_W-1:0] fifo_cnt_o;

  modport master (
    output wr_valid_i, wr_data_i,
    input  wr_ready_o, tx_o, busy_o, fifo_cnt_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i,
    output wr_ready_o, tx_o, busy_o, fifo_cnt_o
  );
endinterface

// File: rtl/uart_tx_fifo_fifo.sv
// rtl/uart_tx_fifo_fifo.sv - byte FIFO feeding the transmitter; head is read combinationally
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_BITS-1:0]     data_i,
  input  logic                     pop_i,
  output logic [DATA_BITS-1:0]     data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers are AW bits wide, so power-of-two depth makes wrap free
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1/8N2 UART transmitter fed by a small byte FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_fifo_if.slave  bus
);
  localparam int BAUD_W = $clog2(CLK_DIV);

  uart_state_e          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic                 baud_end;

  assign bus.wr_ready_o = !fifo_full;
  assign fifo_push      = bus.wr_valid_i && !fifo_full;
  assign bus.fifo_cnt_o = fifo_cnt;
  assign bus.tx_o       = tx_q;
  assign bus.busy_o     = (state_q != IDLE) || (fifo_cnt != '0);
  assign baud_end       = (baud_q == BAUD_W'(CLK_DIV - 1));

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (bus.wr_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // bit_q indexes data bits in DATA and counts stop bits in STOP
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state one cycle later, giving a glitch-free registered output
    case (state_q)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_q[bit_q];
      default: tx_d = STOP_LEVEL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo at CLK_DIV=4, one and two stop bits
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo_if #(.FIFO_DEPTH(4)) ifa ();
  uart_tx_fifo_if #(.FIFO_DEPTH(4)) ifb ();

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic txv(input int sel);
    return (sel != 0) ? ifb.tx_o : ifa.tx_o;
  endfunction

  task automatic put1(input int sel, input logic [7:0] d);
    if (sel != 0) begin
      ifb.wr_valid_i = 1'b1;
      ifb.wr_data_i  = d;
    end else begin
      ifa.wr_valid_i = 1'b1;
      ifa.wr_data_i  = d;
    end
    @(negedge clk);
    ifa.wr_valid_i = 1'b0;
    ifb.wr_valid_i = 1'b0;
  endtask

  task automatic wait_start(input int sel, output bit ok);
    int g = 0;
    while (txv(sel) !== 1'b0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    ok = (g < 400);
    if (!ok) chk("start_timeout", 0, 1);
  endtask

  // Streams exp_q into dut_a with wr_valid held; reports occupancy when ready first drops/returns
  task automatic send_all(output int full_cnt, output int full_idx, output int back_cnt);
    int idx = 0;
    int g = 0;
    bit saw_full = 0;
    bit back = 0;
    full_cnt = -1;
    full_idx = -1;
    back_cnt = -1;
    ifa.wr_valid_i = 1'b1;
    ifa.wr_data_i  = exp_q[0];
    while (idx < exp_q.size() && g < 2000) begin
      if (ifa.wr_ready_o) begin
        if (saw_full && !back) begin
          back = 1;
          back_cnt = int'(ifa.fifo_cnt_o);
        end
        idx++;
      end else if (!saw_full) begin
        saw_full = 1;
        full_cnt = int'(ifa.fifo_cnt_o);
        full_idx = idx;
      end
      @(negedge clk);
      g++;
      if (idx < exp_q.size()) ifa.wr_data_i = exp_q[idx];
      else ifa.wr_valid_i = 1'b0;
    end
    ifa.wr_valid_i = 1'b0;
    if (g >= 2000) chk("send_timeout", 0, 1);
  endtask

  // Samples each bit two cycles into its four-cycle window
  task automatic rx_frames(input int sel, input int n);
    int prev = 0;
    for (int f = 0; f < n; f++) begin
      logic [7:0] d;
      logic       stp;
      int         t0;
      bit         ok;
      wait_start(sel, ok);
      if (!ok) return;
      t0 = cyc;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (4) @(negedge clk);
        d[j] = txv(sel);
      end
      repeat (4) @(negedge clk);
      stp = txv(sel);
      chk("rx_data", d, exp_q[f]);
      chk("rx_stop", stp, 1);
      if (f > 0) chk("rx_gap", t0 - prev, 40);
      prev = t0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, fi, bc;
    bit ok;
    bit saw_low;
    logic [7:0] v;
    logic exp_bit;

    ifa.wr_valid_i = 1'b1;
    ifa.wr_data_i  = 8'hEE;
    ifb.wr_valid_i = 1'b0;
    ifb.wr_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", ifa.tx_o, 1);
    chk("rst_busy", ifa.busy_o, 0);
    chk("rst_ready", ifa.wr_ready_o, 1);
    chk("rst_cnt", ifa.fifo_cnt_o, 0);
    chk("rst_cnt_b", ifb.fifo_cnt_o, 0);
    rst = 1'b0;
    ifa.wr_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_write_ignored", ifa.fifo_cnt_o, 0);
    chk("rst_idle_tx", ifa.tx_o, 1);

    // Single 0xA5 frame
    v = 8'hA5;
    put1(0, v);
    chk("a5_cnt", ifa.fifo_cnt_o, 1);
    chk("a5_busy", ifa.busy_o, 1);
    @(negedge clk);
    chk("a5_pre_start", ifa.tx_o, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4) exp_bit = 1'b0;
      else if (i < 36) exp_bit = v[(i - 4) / 4];
      else exp_bit = 1'b1;
      chk($sformatf("a5_wave%0d", i), ifa.tx_o, exp_bit);
    end
    chk("a5_busy_after", ifa.busy_o, 0);
    chk("a5_cnt_after", ifa.fifo_cnt_o, 0);

    // Six bytes streamed into a depth-4 FIFO
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fork
      send_all(fc, fi, bc);
      rx_frames(0, 6);
    join
    chk("full_cnt", fc, 4);
    chk("full_idx", fi, 5);
    chk("ready_back_cnt", bc, 3);
    repeat (4) @(negedge clk);
    chk("stream_busy_after", ifa.busy_o, 0);

    // Two stop bits, all-zero byte
    put1(1, 8'h00);
    @(negedge clk);
    chk("z_pre_start", ifb.tx_o, 1);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      chk($sformatf("z_wave%0d", i), ifb.tx_o, (i < 36) ? 1'b0 : 1'b1);
    end
    chk("z_busy_after", ifb.busy_o, 0);

    // Loopback pattern
    exp_q = '{8'h55, 8'hFF, 8'h00, 8'h81};
    fork
      send_all(fc, fi, bc);
      rx_frames(0, 4);
    join
    repeat (4) @(negedge clk);
    chk("loop_busy_after", ifa.busy_o, 0);

    // Reset in the middle of data bit 3 of 0x3C with two bytes queued
    exp_q = '{8'h3C, 8'hA1, 8'hB2};
    fork
      send_all(fc, fi, bc);
      begin
        wait_start(0, ok);
        if (ok) begin
          repeat (17) @(negedge clk);
          chk("mid_bit3", ifa.tx_o, 1);
          chk("mid_cnt", ifa.fifo_cnt_o, 2);
          rst = 1'b1;
          @(negedge clk);
          chk("abort_tx", ifa.tx_o, 1);
          chk("abort_cnt", ifa.fifo_cnt_o, 0);
          chk("abort_busy", ifa.busy_o, 0);
          chk("abort_ready", ifa.wr_ready_o, 1);
          rst = 1'b0;
          saw_low = 0;
          repeat (100) begin
            @(negedge clk);
            if (ifa.tx_o !== 1'b1) saw_low = 1;
          end
          chk("no_frame_after_rst", saw_low, 0);
          chk("idle_busy_after_rst", ifa.busy_o, 0);
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
